// File: rtl/prbs_bit_checker.sv
// Self-synchronising checker for the XNOR LFSR serial stream: acquires, verifies, locks, counts errors.
// Optional all-ones lockup detector enabled by defining PRBS_CHK_STUCK_DET_EN (adds the stuck output).
module prbs_bit_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic [1:0]       sync_state
`ifdef PRBS_CHK_STUCK_DET_EN
  ,
  output logic             stuck
`endif
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   h, h_nxt, h_shift;
  logic [FW-1:0]      fill, fill_nxt;
  logic [RW-1:0]      run, run_nxt;
  logic [MW-1:0]      miss, miss_nxt;
  logic [CNT_W-1:0]   err_nxt, bit_nxt;
  logic               pulse_nxt;
  logic               pred, mism, block;

`ifdef PRBS_CHK_STUCK_DET_EN
  logic stuck_q, stuck_nxt;
  assign stuck = stuck_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACQ;
      h         <= '0;
      fill      <= '0;
      run       <= '0;
      miss      <= '0;
      err_count <= '0;
      bit_count <= '0;
      err_pulse <= 1'b0;
`ifdef PRBS_CHK_STUCK_DET_EN
      stuck_q   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      h         <= h_nxt;
      fill      <= fill_nxt;
      run       <= run_nxt;
      miss      <= miss_nxt;
      err_count <= err_nxt;
      bit_count <= bit_nxt;
      err_pulse <= pulse_nxt;
`ifdef PRBS_CHK_STUCK_DET_EN
      stuck_q   <= stuck_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    fill_nxt  = fill;
    run_nxt   = run;
    miss_nxt  = miss;
    err_nxt   = err_count;
    bit_nxt   = bit_count;
    pulse_nxt = 1'b0;
    block     = 1'b0;
    // Prediction uses the history before the incoming bit is shifted in.
    pred      = ~(h[0] ^ h[1]);
    mism      = din ^ pred;
    h_shift   = {din, h[WIDTH-1:1]};

`ifdef PRBS_CHK_STUCK_DET_EN
    stuck_nxt = stuck_q;
    if (enable) begin
      if (&h_shift) begin
        if (state != ACQ) stuck_nxt = 1'b1;
      end else begin
        stuck_nxt = 1'b0;
      end
    end
    block = stuck_nxt;
`endif

    if (enable) begin
      // The received bit always enters the history so a corrupted line resynchronises.
      h_nxt = h_shift;
      case (state)
        ACQ: begin
          if (fill == FILL_LAST) begin
            state_nxt = VERIFY;
            run_nxt   = '0;
          end else begin
            fill_nxt = fill + 1'b1;
          end
        end
        VERIFY: begin
          if (mism) begin
            run_nxt = '0;
          end else if (run == RUN_LAST) begin
            if (!block) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            run_nxt = run + 1'b1;
          end
        end
        LOCKED: begin
          if (bit_count != '1) bit_nxt = bit_count + 1'b1;
          if (mism) begin
            pulse_nxt = 1'b1;
            if (err_count != '1) err_nxt = err_count + 1'b1;
            if (miss == MISS_LAST) begin
              state_nxt = ACQ;
              fill_nxt  = '0;
            end else begin
              miss_nxt = miss + 1'b1;
            end
          end else begin
            miss_nxt = '0;
          end
          if (block) begin
            state_nxt = ACQ;
            fill_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ACQ;
          fill_nxt  = '0;
        end
      endcase
    end

    if (clear_cnt) begin
      err_nxt = '0;
      bit_nxt = '0;
    end
  end

  always_comb begin
    locked     = (state == LOCKED);
    sync_state = state;
  end

endmodule

// File: tb/tb_prbs_bit_checker.sv
// Directed bench: main checker (CNT_W=16) and a narrow-counter twin (CNT_W=4) share one stimulus stream.
module tb_prbs_bit_checker;

  logic        clk = 1'b0;
  logic        reset, enable, din, clear_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count, bit_count;
  logic [1:0]  sync_state;
  logic        sat_locked, sat_err_pulse;
  logic [3:0]  sat_err_count, sat_bit_count;
  logic [1:0]  sat_sync_state;
`ifdef PRBS_CHK_STUCK_DET_EN
  logic        stuck, sat_stuck;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [0:14] seq;
  int          idx;

  always #5 clk = ~clk;

  prbs_bit_checker #(.WIDTH(4), .LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .din(din), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .bit_count(bit_count), .sync_state(sync_state)
`ifdef PRBS_CHK_STUCK_DET_EN
    , .stuck(stuck)
`endif
  );

  prbs_bit_checker #(.WIDTH(4), .LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .din(din), .clear_cnt(clear_cnt),
    .locked(sat_locked), .err_pulse(sat_err_pulse), .err_count(sat_err_count),
    .bit_count(sat_bit_count), .sync_state(sat_sync_state)
`ifdef PRBS_CHK_STUCK_DET_EN
    , .stuck(sat_stuck)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic send_raw(input logic b, input logic clr);
    enable    = 1'b1;
    din       = b;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    enable    = 1'b0;
    clear_cnt = 1'b0;
  endtask

  // Next transmitter bit, optionally inverted to model a line error.
  task automatic send(input logic inv, input logic clr);
    send_raw(seq[idx] ^ inv, clr);
    idx = (idx == 14) ? 0 : idx + 1;
  endtask

  task automatic idle();
    enable = 1'b0;
    din    = ~din;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idx   = 0;
  endtask

  initial begin
    // One period of the 4-bit XNOR sequence from seed 0001, x(n+4) = ~(x(n) ^ x(n+1)).
    seq       = 15'b000111011001010;
    idx       = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    din       = 1'b0;
    clear_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_state", sync_state, 0);
    check("rst_err", err_count, 0);
    check("rst_bits", bit_count, 0);
    check("rst_pulse", err_pulse, 0);
    reset = 1'b0;

    // Acquisition and lock on a clean stream.
    repeat (3) send(0, 0);
    check("acq_state", sync_state, 0);
    send(0, 0);
    check("verify_entry", sync_state, 1);
    repeat (7) send(0, 0);
    check("lock_11_locked", locked, 0);
    check("lock_11_state", sync_state, 1);
    send(0, 0);
    check("lock_12_locked", locked, 1);
    check("lock_12_state", sync_state, 2);
    check("lock_err", err_count, 0);
    check("lock_bits", bit_count, 0);
    repeat (5) send(0, 0);
    check("bits_5", bit_count, 5);

    // One flipped bit also corrupts the two predictions that later read it back from history.
    send(1, 0);
    check("single_pulse", err_pulse, 1);
    check("single_err", err_count, 1);
    check("single_locked", locked, 1);
    check("single_bits", bit_count, 6);
    send(0, 0);
    check("single_pulse_end", err_pulse, 0);
    repeat (3) send(0, 0);
    check("single_err_echo", err_count, 3);
    check("single_locked2", locked, 1);
    send(0, 0);
    check("single_bits2", bit_count, 11);

    // Three flipped bits then a clean one give four consecutive mispredictions.
    repeat (3) send(1, 0);
    check("loss_hold", locked, 1);
    send(0, 0);
    check("loss_locked", locked, 0);
    check("loss_state", sync_state, 0);
    check("loss_err", err_count, 7);
    check("loss_pulse", err_pulse, 1);
    check("loss_bits", bit_count, 15);
    check("loss_sat_bits", sat_bit_count, 15);
    repeat (11) send(0, 0);
    check("relock_11", locked, 0);
    send(0, 0);
    check("relock_12", locked, 1);
    check("relock_err", err_count, 7);

    // Reset dominates a simultaneous strobe and clear.
    reset     = 1'b1;
    enable    = 1'b1;
    clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    enable    = 1'b0;
    clear_cnt = 1'b0;
    idx       = 0;
    check("midrst_locked", locked, 0);
    check("midrst_state", sync_state, 0);
    check("midrst_err", err_count, 0);

    // Gapped strobe: same lock point counted in valid bits.
    for (int i = 1; i <= 12; i++) begin
      send(0, 0);
      if (i == 4) check("gap_verify", sync_state, 1);
      if (i == 11) check("gap_11", locked, 0);
      if (i == 12) check("gap_12", locked, 1);
      idle();
      idle();
      if (i == 4) check("gap_idle_state", sync_state, 1);
    end

    // Clear coinciding with an error: clear wins.
    send(1, 1);
    check("clr_err", err_count, 0);
    check("clr_bits", bit_count, 0);
    check("clr_pulse", err_pulse, 1);
    check("clr_locked", locked, 1);
    repeat (3) send(0, 0);
    check("clr_echo_pulse", err_pulse, 1);
    check("clr_echo_err", err_count, 1);
    check("clr_echo_bits", bit_count, 3);
    idle();
    check("idle_pulse", err_pulse, 0);
    check("idle_err", err_count, 1);
    send(0, 0);
    check("clr_echo2", err_count, 2);
    send(0, 0);

    // Saturation: 20 injections, each yielding three mispredictions.
    clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
    check("sat_cleared", sat_err_count, 0);
    for (int k = 0; k < 20; k++) begin
      send(1, 0);
      check("sat_pulse", sat_err_pulse, 1);
      repeat (4) send(0, 0);
    end
    check("sat_err", sat_err_count, 15);
    check("sat_bits", sat_bit_count, 15);
    check("sat_locked", sat_locked, 1);
    check("wide_err", err_count, 60);
    check("wide_bits", bit_count, 100);

    // Constant-ones line.
    do_reset();
`ifdef PRBS_CHK_STUCK_DET_EN
    repeat (12) send_raw(1'b1, 1'b0);
    check("stuck_set", stuck, 1);
    check("stuck_nolock", locked, 0);
    send_raw(1'b0, 1'b0);
    check("stuck_clear", stuck, 0);
`else
    repeat (11) send_raw(1'b1, 1'b0);
    check("ones_11", locked, 0);
    send_raw(1'b1, 1'b0);
    check("ones_12", locked, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
